// File: rtl/bitser_sched.sv
// Bit-serial beat scheduler: for each tile, walks the (weight-bit, data-bit) pairs one
// anti-diagonal at a time and issues one address beat per cycle, with accumulator controls.
module bitser_sched #(
  parameter int BWADDR = 21
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        pw,
  input  logic [3:0]        pd,
  input  logic [BWADDR-1:0] wbase,
  input  logic [BWADDR-1:0] dbase,
  input  logic [15:0]       ntile,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              vld,
  output logic [BWADDR-1:0] waddr,
  output logic [BWADDR-1:0] daddr,
  output logic              sh,
  output logic              accclr,
  output logic              last
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state_q, state_d;
  logic [3:0]          pw_q, pw_d, pd_q, pd_d;
  logic [BWADDR-1:0]   wbase_q, wbase_d, dbase_q, dbase_d;
  logic [15:0]         ntile_q, ntile_d, tile_q, tile_d;
  logic [BWADDR-1:0]   tpw_q, tpw_d, tpd_q, tpd_d;
  logic [4:0]          k_q, k_d;
  logic [3:0]          id_q, id_d, iw_q, iw_d;
  logic                first_q, first_d, walk_done_q, walk_done_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d, vld_q, vld_d;
  logic                sh_q, sh_d, accclr_q, accclr_d, last_q, last_d;
  logic [BWADDR-1:0]   waddr_q, waddr_d, daddr_q, daddr_d;

  // Diagonal walk helpers: last diagonal index, end of the current diagonal, start of the next.
  logic [4:0] k_last, k_nxt;
  logic [3:0] pd_m1, id_end, id_start, iw_start;

  assign k_last   = 5'(pw_q) + 5'(pd_q) - 5'd2;
  assign pd_m1    = pd_q - 4'd1;
  assign id_end   = (k_q < 5'(pd_m1)) ? k_q[3:0] : pd_m1;
  assign k_nxt    = k_q + 5'd1;
  assign id_start = (k_nxt >= 5'(pw_q)) ? 4'(k_nxt - 5'(pw_q) + 5'd1) : 4'd0;
  assign iw_start = 4'(k_nxt - 5'(id_start));

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    pw_d        = pw_q;
    pd_d        = pd_q;
    wbase_d     = wbase_q;
    dbase_d     = dbase_q;
    ntile_d     = ntile_q;
    tile_d      = tile_q;
    tpw_d       = tpw_q;
    tpd_d       = tpd_q;
    k_d         = k_q;
    id_d        = id_q;
    iw_d        = iw_q;
    first_d     = first_q;
    walk_done_d = walk_done_q;
    busy_d      = busy_q;
    waddr_d     = waddr_q;
    daddr_d     = daddr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    vld_d       = 1'b0;
    sh_d        = 1'b0;
    accclr_d    = 1'b0;
    last_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          pw_d        = pw;
          pd_d        = pd;
          wbase_d     = wbase;
          dbase_d     = dbase;
          ntile_d     = ntile;
          tile_d      = '0;
          tpw_d       = '0;
          tpd_d       = '0;
          k_d         = '0;
          id_d        = '0;
          iw_d        = '0;
          first_d     = 1'b1;
          walk_done_d = 1'b0;
          if (pw == 4'd0 || pd == 4'd0) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (ntile == 16'd0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (walk_done_q) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!hold) begin
          vld_d    = 1'b1;
          waddr_d  = wbase_q + tpw_q + BWADDR'(iw_q);
          daddr_d  = dbase_q + tpd_q + BWADDR'(id_q);
          sh_d     = first_q && (k_q != 5'd0);
          accclr_d = (k_q == 5'd0);
          last_d   = (k_q == k_last);
          if (id_q != id_end) begin
            id_d    = id_q + 4'd1;
            iw_d    = iw_q - 4'd1;
            first_d = 1'b0;
          end else if (k_q != k_last) begin
            k_d     = k_nxt;
            id_d    = id_start;
            iw_d    = iw_start;
            first_d = 1'b1;
          end else begin
            // Tile boundary: offsets step by the precisions, so no multiplier is needed.
            k_d     = '0;
            id_d    = '0;
            iw_d    = '0;
            first_d = 1'b1;
            tile_d  = tile_q + 16'd1;
            tpw_d   = tpw_q + BWADDR'(pw_q);
            tpd_d   = tpd_q + BWADDR'(pd_q);
            if (tile_q == 16'(ntile_q - 16'd1)) walk_done_d = 1'b1;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clr is a synchronous reset, so it is just the highest-priority branch of this clocked block.
    if (clr) begin
      state_q     <= IDLE;
      pw_q        <= '0;
      pd_q        <= '0;
      wbase_q     <= '0;
      dbase_q     <= '0;
      ntile_q     <= '0;
      tile_q      <= '0;
      tpw_q       <= '0;
      tpd_q       <= '0;
      k_q         <= '0;
      id_q        <= '0;
      iw_q        <= '0;
      first_q     <= 1'b0;
      walk_done_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      vld_q       <= 1'b0;
      waddr_q     <= '0;
      daddr_q     <= '0;
      sh_q        <= 1'b0;
      accclr_q    <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      pd_q        <= pd_d;
      wbase_q     <= wbase_d;
      dbase_q     <= dbase_d;
      ntile_q     <= ntile_d;
      tile_q      <= tile_d;
      tpw_q       <= tpw_d;
      tpd_q       <= tpd_d;
      k_q         <= k_d;
      id_q        <= id_d;
      iw_q        <= iw_d;
      first_q     <= first_d;
      walk_done_q <= walk_done_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      vld_q       <= vld_d;
      waddr_q     <= waddr_d;
      daddr_q     <= daddr_d;
      sh_q        <= sh_d;
      accclr_q    <= accclr_d;
      last_q      <= last_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign vld    = vld_q;
  assign waddr  = waddr_q;
  assign daddr  = daddr_q;
  assign sh     = sh_q;
  assign accclr = accclr_q;
  assign last   = last_q;

endmodule

// File: tb/tb_bitser_sched.sv
// Bench for bitser_sched: a reference walk fills a queue of expected beats per job,
// and each issued beat is popped and compared as the scheduler emits it.
module tb_bitser_sched;

  localparam int BW = 21;

  logic          clk = 1'b0;
  logic          clr, start, hold;
  logic [3:0]    pw_i, pd_i;
  logic [BW-1:0] wbase_i, dbase_i;
  logic [15:0]   ntile_i;
  logic          busy, done, err, vld, sh, accclr, last;
  logic [BW-1:0] waddr, daddr;

  typedef struct packed {
    logic [BW-1:0] w;
    logic [BW-1:0] d;
    logic          sh;
    logic          acc;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  bitser_sched #(.BWADDR(BW)) dut (
    .clk(clk), .clr(clr), .start(start), .pw(pw_i), .pd(pd_i),
    .wbase(wbase_i), .dbase(dbase_i), .ntile(ntile_i), .hold(hold),
    .busy(busy), .done(done), .err(err), .vld(vld),
    .waddr(waddr), .daddr(daddr), .sh(sh), .accclr(accclr), .last(last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference walk written straight from the diagonal ordering, using real products.
  task automatic push_model(input int pw, input int pd, input logic [BW-1:0] wb,
                            input logic [BW-1:0] db, input int nt);
    for (int t = 0; t < nt; t++) begin
      int b = 0;
      for (int k = 0; k <= pw + pd - 2; k++) begin
        int lo = (k - pw + 1 > 0) ? k - pw + 1 : 0;
        int hi = (k < pd - 1) ? k : pd - 1;
        for (int id = lo; id <= hi; id++) begin
          beat_t e;
          e.w    = wb + BW'(t * pw + (k - id));
          e.d    = db + BW'(t * pd + id);
          e.sh   = (id == lo) && (k > 0);
          e.acc  = (b == 0);
          e.last = (b == pw * pd - 1);
          exp_q.push_back(e);
          b++;
        end
      end
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_job(input int pw, input int pd, input logic [BW-1:0] wb,
                         input logic [BW-1:0] db, input int nt, input int hold_after,
                         input int hold_cycles, input int clr_beat);
    bit exp_err = (pw == 0 || pd == 0);
    int nbeats  = exp_err ? 0 : nt * pw * pd;
    int hc      = (hold_after >= 0 && hold_after < nbeats) ? hold_cycles : 0;
    int exp_done_c = (nbeats == 0) ? 1 : nbeats + 2 + hc;
    int c = 0, idx = 0, done_c = -1, h_left = 0;
    if (!exp_err) push_model(pw, pd, wb, db, nt);
    start = 1'b1; pw_i = 4'(pw); pd_i = 4'(pd);
    wbase_i = wb; dbase_i = db; ntile_i = 16'(nt); hold = 1'b0;
    while (done_c < 0 && c < 400) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (c == 1) begin
        check("busy_after_start", busy, nbeats > 0);
        check("no_vld_with_busy_rise", vld, 0);
        // Keep start asserted with junk config: must be ignored for the rest of the job.
        pw_i = 4'($urandom); pd_i = 4'($urandom);
        wbase_i = BW'($urandom); dbase_i = BW'($urandom); ntile_i = 16'($urandom);
      end
      if (vld) begin
        if (exp_q.size() == 0) check("unexpected_beat", vld, 0);
        else begin
          beat_t e = exp_q.pop_front();
          check("waddr", waddr, e.w);
          check("daddr", daddr, e.d);
          check("sh", sh, e.sh);
          check("accclr", accclr, e.acc);
          check("last", last, e.last);
          check("busy_in_beat", busy, 1);
        end
        idx++;
        if (idx - 1 == clr_beat) begin
          clr = 1'b1;
          @(posedge clk);
          @(negedge clk);
          clr = 1'b0;
          start = 1'b0;
          check("clr_busy", busy, 0);
          check("clr_vld", vld, 0);
          check("clr_done", done, 0);
          check("clr_err", err, 0);
          exp_q.delete();
          return;
        end
      end else begin
        check("ctrl_quiet_when_idle", {29'd0, sh, accclr, last}, 0);
      end
      if (done) begin
        done_c = c;
        check("err_at_done", err, exp_err);
        check("busy_at_done", busy, 0);
      end
      if (vld && idx - 1 == hold_after) h_left = hold_cycles;
      hold = (h_left > 0);
      if (h_left > 0) h_left--;
    end
    check("done_cycle", done_c, exp_done_c);
    check("beats_remaining", exp_q.size(), 0);
    hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("err_one_cycle", err, 0);
    check("start_in_fin_ignored", busy, 0);
    start = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; hold = 1'b0;
    pw_i = '0; pd_i = '0; wbase_i = '0; dbase_i = '0; ntile_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_vld", vld, 0);
    check("rst_waddr", waddr, 0);
    check("rst_daddr", daddr, 0);
    check("rst_ctrl", {29'd0, sh, accclr, last}, 0);

    // clr overrides a start presented at the same edge.
    start = 1'b1; pw_i = 4'd2; pd_i = 4'd2; ntile_i = 16'd1;
    @(posedge clk);
    @(negedge clk);
    check("clr_beats_start", busy, 0);
    clr = 1'b0;

    run_job(2, 2, 21'h100, 21'h200, 1, -1, 0, -1);
    run_job(3, 1, 21'h0, 21'h10, 2, -1, 0, -1);
    run_job(2, 2, 21'h100, 21'h200, 1, 1, 3, -1);
    run_job(0, 3, 21'h40, 21'h50, 2, -1, 0, -1);
    run_job(3, 0, 21'h40, 21'h50, 2, -1, 0, -1);
    run_job(2, 2, 21'h100, 21'h200, 0, -1, 0, -1);
    run_job(2, 2, 21'h100, 21'h200, 1, -1, 0, 2);
    run_job(2, 2, 21'h100, 21'h200, 1, -1, 0, -1);
    run_job(2, 1, 21'h1FFFFF, 21'h7, 1, -1, 0, -1);
    run_job(1, 1, 21'h20, 21'h30, 3, -1, 0, -1);
    run_job(2, 3, 21'h1000, 21'h2000, 2, 4, 2, -1);
    run_job(3, 4, 21'h1FFFF0, 21'h1FFFFE, 3, 5, 2, -1);
    run_job(15, 15, 21'h500, 21'h600, 1, 100, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
